// File: rtl/cave_input_pkg.sv
// cave_input_pkg: keymap tables, joystick bit layout and helpers shared by the input mapper.
package cave_input_pkg;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       ext_dc;
    } key_entry_t;

    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;
    localparam int BTN0  = 4;

    // Keymap slots: right, left, down, up, btn0..btn2, start, coin, pause. Code 00 marks an unmapped slot.
    localparam int SLOTS     = 10;
    localparam int KEY_BTNS  = 3;
    localparam int S_START   = 7;
    localparam int S_COIN    = 8;
    localparam int S_PAUSE   = 9;

    localparam key_entry_t P1_MAP [SLOTS] = '{
        '{8'h74, 1'b1, 1'b0}, '{8'h6B, 1'b1, 1'b0}, '{8'h72, 1'b1, 1'b0}, '{8'h75, 1'b1, 1'b0},
        '{8'h14, 1'b0, 1'b1}, '{8'h11, 1'b0, 1'b1}, '{8'h29, 1'b0, 1'b0},
        '{8'h16, 1'b0, 1'b0}, '{8'h2E, 1'b0, 1'b0}, '{8'h4D, 1'b0, 1'b0}
    };

    localparam key_entry_t P2_MAP [SLOTS] = '{
        '{8'h34, 1'b0, 1'b0}, '{8'h23, 1'b0, 1'b0}, '{8'h2B, 1'b0, 1'b0}, '{8'h2D, 1'b0, 1'b0},
        '{8'h1C, 1'b0, 1'b0}, '{8'h1B, 1'b0, 1'b0}, '{8'h15, 1'b0, 1'b0},
        '{8'h1E, 1'b0, 1'b0}, '{8'h36, 1'b0, 1'b0}, '{8'h00, 1'b0, 1'b0}
    };

    // Service keys: index 0 is key 9, index 1 is key 0.
    localparam key_entry_t SVC_MAP [2] = '{'{8'h46, 1'b0, 1'b0}, '{8'h45, 1'b0, 1'b0}};

    function automatic int jw(input int buttons);
        return buttons + 7;
    endfunction

    function automatic logic key_match(input key_entry_t e, input logic [8:0] k);
        return e.code != 8'h00 && e.code == k[7:0] && (e.ext_dc || e.ext == k[8]);
    endfunction

endpackage

// File: rtl/cave_input_mapper_pulse.sv
// cave_pulse_stretcher: turns a rising edge on trig into a fixed-width, non-retriggerable pulse.
module cave_pulse_stretcher #(
    parameter logic [15:0] CYCLES = 16'd4096
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic trig,
    output logic pulse
);
    logic        trig_d;
    logic [15:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            trig_d <= 1'b0;
            cnt    <= '0;
        end else begin
            trig_d <= trig;
            cnt    <= (trig && !trig_d && cnt == '0) ? CYCLES : (cnt == '0 ? '0 : cnt - 16'd1);
        end
    end

    assign pulse = cnt != '0;
endmodule

// File: rtl/cave_input_mapper.sv
// cave_input_mapper: merges ps2 keyboard state with packed joysticks, adding coin shaping,
// per-button autofire and a latched pause toggle.
module cave_input_mapper
    import cave_input_pkg::*;
#(
    parameter int          PLAYERS         = 2,
    parameter int          BUTTONS         = 3,
    parameter logic [15:0] COIN_CYCLES     = 16'd4096,
    parameter int          AUTOFIRE_FRAMES = 4
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic [10:0]                     ps2_key,
    input  logic [PLAYERS*jw(BUTTONS)-1:0]  joystick,
    input  logic [PLAYERS*BUTTONS-1:0]      autofire_en,
    input  logic                            vblank,
    output logic [PLAYERS*4-1:0]            dirs,
    output logic [PLAYERS*BUTTONS-1:0]      buttons,
    output logic [PLAYERS-1:0]              start,
    output logic [PLAYERS-1:0]              coin,
    output logic                            pause,
    output logic [1:0]                      service
);
    localparam int          JW         = jw(BUTTONS);
    localparam int          KP         = PLAYERS < 2 ? PLAYERS : 2;
    localparam int          KB         = BUTTONS < KEY_BTNS ? BUTTONS : KEY_BTNS;
    localparam logic [15:0] FRAME_LAST = 16'(2 * AUTOFIRE_FRAMES - 1);

    logic                           old_toggle;
    logic                           ps2_event;
    logic [1:0][SLOTS-1:0]          key_st;
    logic [1:0]                     svc_key;
    logic [PLAYERS-1:0][JW-1:0]     raw;
    logic                           pause_any;
    logic                           pause_d;
    logic                           vblank_d;
    logic [15:0]                    frame_cnt;
    logic                           phase;

    assign ps2_event = ps2_key[10] != old_toggle;
    assign phase     = frame_cnt < 16'(AUTOFIRE_FRAMES);

    // old_toggle tracks the toggle even in reset so nothing fires when reset releases.
    always_ff @(posedge clk_sys) begin
        old_toggle <= ps2_key[10];
        if (!reset_n) begin
            key_st  <= '0;
            svc_key <= '0;
        end else if (ps2_event) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (key_match(P1_MAP[i], ps2_key[8:0])) key_st[0][i] <= ps2_key[9];
                if (key_match(P2_MAP[i], ps2_key[8:0])) key_st[1][i] <= ps2_key[9];
            end
            for (int i = 0; i < 2; i++)
                if (key_match(SVC_MAP[i], ps2_key[8:0])) svc_key[i] <= ps2_key[9];
        end
    end

    always_comb begin
        raw = joystick;
        for (int p = 0; p < KP; p++) begin
            raw[p][UP:RIGHT] = raw[p][UP:RIGHT] | key_st[p][UP:RIGHT];
            for (int b = 0; b < KB; b++)
                raw[p][BTN0+b] = raw[p][BTN0+b] | key_st[p][BTN0+b];
            raw[p][JW-3] = raw[p][JW-3] | key_st[p][S_START];
            raw[p][JW-2] = raw[p][JW-2] | key_st[p][S_COIN];
            raw[p][JW-1] = raw[p][JW-1] | key_st[p][S_PAUSE];
        end
    end

    always_comb begin
        pause_any = 1'b0;
        for (int p = 0; p < PLAYERS; p++)
            pause_any = pause_any | raw[p][JW-1];
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dirs      <= '0;
            buttons   <= '0;
            start     <= '0;
            pause     <= 1'b0;
            pause_d   <= 1'b0;
            vblank_d  <= 1'b0;
            frame_cnt <= '0;
            service   <= '0;
        end else begin
            vblank_d <= vblank;
            pause_d  <= pause_any;
            service  <= svc_key;
            if (vblank && !vblank_d)
                frame_cnt <= frame_cnt == FRAME_LAST ? '0 : frame_cnt + 16'd1;
            if (pause_any && !pause_d)
                pause <= !pause;
            for (int p = 0; p < PLAYERS; p++) begin
                dirs[p*4 +: 4] <= raw[p][UP:RIGHT];
                start[p]       <= raw[p][JW-3];
                for (int b = 0; b < BUTTONS; b++)
                    buttons[p*BUTTONS+b] <= raw[p][BTN0+b] & (autofire_en[p*BUTTONS+b] ? phase : 1'b1);
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        cave_pulse_stretcher #(.CYCLES(COIN_CYCLES)) u_coin (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .trig    (raw[p][JW-2]),
            .pulse   (coin[p])
        );
    end
endmodule

// File: tb/tb_cave_input_mapper.sv
// tb_cave_input_mapper: randomized and directed checks of the input mapper against a keymap-level model.
module tb_cave_input_mapper;
    localparam int P  = 2;
    localparam int B  = 3;
    localparam int JW = B + 7;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [10:0]       ps2_key = '0;
    logic [P*JW-1:0]   joystick = '0;
    logic [P*B-1:0]    autofire_en = '0;
    logic              vblank = 1'b0;
    logic [P*4-1:0]    dirs;
    logic [P*B-1:0]    buttons;
    logic [P-1:0]      start;
    logic [P-1:0]      coin;
    logic              pause;
    logic [1:0]        service;

    int checks = 0;
    int errors = 0;

    // Model: pressed state per {ext, code}; Ctrl/Alt ignore the extended bit.
    bit kd [512];
    logic [7:0] map_code [2][10] = '{
        '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h4D},
        '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h00}
    };
    bit map_ext [2][10] = '{
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
    };
    logic [7:0] rand_codes [22] = '{
        8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h4D, 8'h34,
        8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h46, 8'h45, 8'h5A
    };

    cave_input_mapper #(
        .PLAYERS(P), .BUTTONS(B), .COIN_CYCLES(16'd8), .AUTOFIRE_FRAMES(2)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .autofire_en(autofire_en), .vblank(vblank), .dirs(dirs), .buttons(buttons),
        .start(start), .coin(coin), .pause(pause), .service(service)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic int kidx(input bit ext, input logic [7:0] code);
        return ((code == 8'h14 || code == 8'h11) ? 0 : int'(ext)) * 256 + int'(code);
    endfunction

    function automatic bit exp_bit(input int p, input int j);
        bit k;
        k = map_code[p][j] != 8'h00 && kd[kidx(map_ext[p][j], map_code[p][j])];
        return k || joystick[p*JW+j];
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_key(input bit pr, input bit ex, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pr, ex, code};
        kd[kidx(ex, code)] = pr;
    endtask

    task automatic do_reset;
        joystick = '0;
        autofire_en = '0;
        vblank = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 512; i++) kd[i] = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({dirs, buttons, start, coin, pause, service} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", {dirs, buttons, start, coin, pause, service});
        end
    endtask

    task automatic test_ext_arrow;
        do_reset;
        send_key(1'b1, 1'b1, 8'h75);
        tick(1);
        checks++;
        if (dirs[3] !== 1'b0) begin
            errors++;
            $display("FAIL arrow_latency1: got %b expected 0", dirs[3]);
        end
        tick(1);
        checks++;
        if (dirs !== 8'h08) begin
            errors++;
            $display("FAIL arrow_press: got %h expected 08", dirs);
        end
        send_key(1'b0, 1'b0, 8'h75);
        tick(2);
        checks++;
        if (dirs !== 8'h08) begin
            errors++;
            $display("FAIL arrow_nonext_ignored: got %h expected 08", dirs);
        end
        send_key(1'b0, 1'b1, 8'h75);
        tick(2);
        checks++;
        if (dirs !== 8'h00) begin
            errors++;
            $display("FAIL arrow_release: got %h expected 00", dirs);
        end
    endtask

    task automatic test_merge;
        do_reset;
        joystick[JW+4] = 1'b1;
        tick(1);
        checks++;
        if (buttons[B] !== 1'b1) begin
            errors++;
            $display("FAIL merge_joy: got %b expected 1", buttons[B]);
        end
        send_key(1'b1, 1'b0, 8'h1C);
        tick(2);
        joystick[JW+4] = 1'b0;
        tick(1);
        checks++;
        if (buttons[B] !== 1'b1) begin
            errors++;
            $display("FAIL merge_key_held: got %b expected 1", buttons[B]);
        end
        send_key(1'b0, 1'b0, 8'h1C);
        tick(2);
        checks++;
        if (buttons !== '0) begin
            errors++;
            $display("FAIL merge_release: got %h expected 0", buttons);
        end
    endtask

    task automatic test_coin;
        int high, rises, first;
        bit prev;
        do_reset;
        joystick[8] = 1'b1;
        high = 0; rises = 0; prev = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (coin[0]) high++;
            if (coin[0] && !prev) rises++;
            if (coin[0] && first < 0) first = i;
            prev = coin[0];
        end
        checks++;
        if (high !== 8 || rises !== 1 || first !== 0) begin
            errors++;
            $display("FAIL coin_hold: got high=%0d rises=%0d first=%0d expected 8 1 0", high, rises, first);
        end
        joystick[8] = 1'b0;
        tick(3);
        joystick[8] = 1'b1;
        high = 0; rises = 0; prev = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) joystick[8] = 1'b0;
            if (i == 5) joystick[8] = 1'b1;
            tick(1);
            if (coin[0]) high++;
            if (coin[0] && !prev) rises++;
            prev = coin[0];
        end
        checks++;
        if (high !== 8 || rises !== 1) begin
            errors++;
            $display("FAIL coin_no_retrigger: got high=%0d rises=%0d expected 8 1", high, rises);
        end
        joystick[8] = 1'b0;
        tick(3);
        send_key(1'b1, 1'b0, 8'h36);
        high = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (coin[1]) high++;
        end
        checks++;
        if (high !== 8 || coin[0] !== 1'b0) begin
            errors++;
            $display("FAIL coin_key_p2: got high=%0d coin0=%b expected 8 0", high, coin[0]);
        end
    endtask

    task automatic test_autofire;
        int frame;
        do_reset;
        autofire_en = 6'b000001;
        joystick[5:4] = 2'b11;
        frame = 0;
        for (int f = 0; f < 10; f++) begin
            tick(3);
            checks++;
            if (buttons[1:0] !== {1'b1, (frame % 4) < 2}) begin
                errors++;
                $display("FAIL autofire_frame%0d: got %b expected %b", f, buttons[1:0], {1'b1, (frame % 4) < 2});
            end
            vblank = 1'b1;
            tick(1);
            vblank = 1'b0;
            frame++;
        end
        tick(3);
        autofire_en = '0;
        tick(1);
        checks++;
        if (buttons[0] !== 1'b1) begin
            errors++;
            $display("FAIL autofire_disable: got %b expected 1 (frame %0d)", buttons[0], frame);
        end
    endtask

    task automatic test_pause;
        logic exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic got_seq [5];
        do_reset;
        send_key(1'b1, 1'b0, 8'h4D);
        tick(2);
        got_seq[0] = pause;
        joystick[JW+9] = 1'b1;
        tick(2);
        got_seq[1] = pause;
        send_key(1'b0, 1'b0, 8'h4D);
        joystick[JW+9] = 1'b0;
        tick(3);
        got_seq[2] = pause;
        joystick[JW+9] = 1'b1;
        tick(2);
        got_seq[3] = pause;
        joystick = '0;
        tick(2);
        joystick[9] = 1'b1;
        joystick[JW+9] = 1'b1;
        tick(2);
        got_seq[4] = pause;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_seq[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL pause_step%0d: got %b expected %b", i, got_seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        send_key(1'b1, 1'b1, 8'h75);
        tick(1);
        send_key(1'b1, 1'b0, 8'h2E);
        tick(4);
        checks++;
        if (coin[0] !== 1'b1 || dirs[3] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got coin=%b up=%b expected 1 1", coin[0], dirs[3]);
        end
        reset_n = 1'b0;
        tick(1);
        checks++;
        if ({dirs, buttons, start, coin, pause, service} !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %0h expected 0", {dirs, buttons, start, coin, pause, service});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 512; i++) kd[i] = 1'b0;
        tick(5);
        checks++;
        if ({dirs, buttons, start, coin, pause, service} !== '0) begin
            errors++;
            $display("FAIL reset_no_spurious: got %0h expected 0", {dirs, buttons, start, coin, pause, service});
        end
        send_key(1'b1, 1'b0, 8'h16);
        tick(2);
        checks++;
        if (start !== 2'b01 || dirs !== '0) begin
            errors++;
            $display("FAIL reset_new_event: got start=%b dirs=%h expected 01 00", start, dirs);
        end
    endtask

    task automatic test_random;
        logic [P*4-1:0] e_dirs;
        logic [P*B-1:0] e_btn;
        logic [P-1:0]   e_start;
        logic [1:0]     e_svc;
        do_reset;
        for (int it = 0; it < 300; it++) begin
            joystick = 20'($urandom) & 20'h3FCFF;
            if ($urandom_range(0, 1) == 1)
                send_key(1'($urandom), 1'($urandom), rand_codes[$urandom_range(0, 21)]);
            tick(2);
            for (int p = 0; p < P; p++) begin
                for (int d = 0; d < 4; d++) e_dirs[p*4+d] = exp_bit(p, d);
                for (int b = 0; b < B; b++) e_btn[p*B+b] = exp_bit(p, 4 + b);
                e_start[p] = exp_bit(p, JW - 3);
            end
            e_svc = {kd[kidx(1'b0, 8'h45)], kd[kidx(1'b0, 8'h46)]};
            checks++;
            if (dirs !== e_dirs) begin
                errors++;
                $display("FAIL rand_dirs it%0d: got %h expected %h", it, dirs, e_dirs);
            end
            checks++;
            if (buttons !== e_btn) begin
                errors++;
                $display("FAIL rand_buttons it%0d: got %h expected %h", it, buttons, e_btn);
            end
            checks++;
            if (start !== e_start) begin
                errors++;
                $display("FAIL rand_start it%0d: got %b expected %b", it, start, e_start);
            end
            checks++;
            if (service !== e_svc) begin
                errors++;
                $display("FAIL rand_service it%0d: got %b expected %b", it, service, e_svc);
            end
        end
    endtask

    initial begin
        test_reset;
        test_ext_arrow;
        test_merge;
        test_coin;
        test_autofire;
        test_pause;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
